// File: rtl/bus_packet_receiver_if.sv
// Bus-side and local-side signal bundle for bus_packet_receiver.
// slave = the receiver endpoint; master = the bus model / local consumer.
interface bus_packet_receiver_if;
  logic [3:0]  crc;
  logic        bus_in;
  logic        bus_out;
  logic        bus_oe;
  logic [63:0] rx_data;
  logic [3:0]  rx_src;
  logic        rx_valid;
  logic        rx_crc_err;
  logic        rx_frame_err;
  logic        busy;

  modport slave (
    input  crc, bus_in,
    output bus_out, bus_oe, rx_data, rx_src, rx_valid, rx_crc_err, rx_frame_err, busy
  );

  modport master (
    output crc, bus_in,
    input  bus_out, bus_oe, rx_data, rx_src, rx_valid, rx_crc_err, rx_frame_err, busy
  );
endinterface

// File: rtl/bus_packet_receiver.sv
// Single-wire bus receive/ack endpoint: deframes 80-bit packets, filters on dst,
// checks CRC, drives the ack. Define RX_CRC_CALC_EN to compute the CRC serially.
module bus_packet_receiver #(
  parameter logic [3:0]  NODE_ADDR = 4'd0,
  parameter int unsigned ACK_LEN   = 2,
  parameter int unsigned PKT_LEN   = 80
) (
  input logic                  clock,
  input logic                  reset,
  bus_packet_receiver_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    RECV,
    CHECK,
    ACK
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [PKT_LEN-1:0] shreg_q, shreg_d;
  logic [3:0]         ack_cnt_q, ack_cnt_d;
  logic               bus_oe_q, bus_oe_d;
  logic               busy_q, busy_d;
  logic [63:0]        rx_data_q, rx_data_d;
  logic [3:0]         rx_src_q, rx_src_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_crc_err_q, rx_crc_err_d;
  logic               rx_frame_err_q, rx_frame_err_d;

  logic frame_ok;
  logic addr_ok;
  logic crc_ok;

  // Bits shift in at the top, so after 80 shifts bit0 sits at index 0.
  assign frame_ok = shreg_q[79] & (shreg_q[10:9] == 2'b11) & ~shreg_q[0];
  assign addr_ok  = (shreg_q[8:5] == NODE_ADDR);

`ifdef RX_CRC_CALC_EN
  logic [3:0] rem_q, rem_d;
  logic       fb;

  always_comb begin
    rem_d = rem_q;
    fb    = rem_q[3] ^ bus.bus_in;
    if (state_q == IDLE) begin
      rem_d = '0;
    end else if (state_q == RECV && cnt_q >= 7'd11 && cnt_q <= 7'd74) begin
      rem_d = {rem_q[2:0], 1'b0} ^ (fb ? bus.crc : 4'h0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign crc_ok = (rem_q == shreg_q[78:75]);
`else
  assign crc_ok = (shreg_q[78:75] == bus.crc);
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    ack_cnt_d      = ack_cnt_q;
    bus_oe_d       = 1'b0;
    rx_data_d      = rx_data_q;
    rx_src_d       = rx_src_q;
    rx_valid_d     = 1'b0;
    rx_crc_err_d   = 1'b0;
    rx_frame_err_d = 1'b0;

    unique case (state_q)
      WAIT_IDLE: begin
        if (bus.bus_in) state_d = IDLE;
      end
      IDLE: begin
        if (!bus.bus_in) begin
          shreg_d = {bus.bus_in, shreg_q[PKT_LEN-1:1]};
          cnt_d   = 7'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        shreg_d = {bus.bus_in, shreg_q[PKT_LEN-1:1]};
        cnt_d   = cnt_q + 7'd1;
        if (cnt_q == 7'(PKT_LEN - 1)) state_d = CHECK;
      end
      CHECK: begin
        if (!frame_ok) begin
          rx_frame_err_d = 1'b1;
          state_d        = WAIT_IDLE;
        end else if (!addr_ok) begin
          state_d = WAIT_IDLE;
        end else if (!crc_ok) begin
          rx_crc_err_d = 1'b1;
          state_d      = WAIT_IDLE;
        end else begin
          rx_data_d  = shreg_q[74:11];
          rx_src_d   = shreg_q[4:1];
          rx_valid_d = 1'b1;
          bus_oe_d   = 1'b1;
          ack_cnt_d  = '0;
          state_d    = ACK;
        end
      end
      ACK: begin
        if (ack_cnt_q == 4'(ACK_LEN - 1)) begin
          state_d = WAIT_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
          bus_oe_d  = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_IDLE;
      cnt_q          <= '0;
      shreg_q        <= '0;
      ack_cnt_q      <= '0;
      bus_oe_q       <= 1'b0;
      busy_q         <= 1'b1;
      rx_data_q      <= '0;
      rx_src_q       <= '0;
      rx_valid_q     <= 1'b0;
      rx_crc_err_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shreg_q        <= shreg_d;
      ack_cnt_q      <= ack_cnt_d;
      bus_oe_q       <= bus_oe_d;
      busy_q         <= busy_d;
      rx_data_q      <= rx_data_d;
      rx_src_q       <= rx_src_d;
      rx_valid_q     <= rx_valid_d;
      rx_crc_err_q   <= rx_crc_err_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  // The receiver only ever drives a high level; releasing is done through bus_oe.
  assign bus.bus_out      = 1'b1;
  assign bus.bus_oe       = bus_oe_q;
  assign bus.busy         = busy_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_src       = rx_src_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_crc_err   = rx_crc_err_q;
  assign bus.rx_frame_err = rx_frame_err_q;

endmodule

// File: doc/bus_packet_receiver.md
Name: bus_packet_receiver

Overview:
- Dedicated receive/acknowledge endpoint for the single-wire node bus.
- Samples the shared bus one bit per clock and deframes the 80-bit packet.
- Filters packets on destination address and checks the CRC field.
- Drives the 2-cycle high acknowledge back onto the bus, then presents the 64-bit payload and source address to local logic.

Parameters:
- NODE_ADDR, 4'd0, this node's bus address; compared with packet dst field [8:5].
- ACK_LEN, 2, number of cycles the ack level (1) is driven; legal range 1..15.
- PKT_LEN, 80, packet length in bits; fixed frame layout, not to be overridden.

Ports:
- clock  in  1  system clock; bus sampled on posedge.
- reset  in  1  asynchronous, active-high reset.
- crc  in  4  expected CRC field value; used as the generator polynomial when RX_CRC_CALC_EN is defined.
- bus_in  in  1  sampled bus level; idle/released bus reads 1.
- bus_out  out  1  level to drive onto the bus.
- bus_oe  out  1  bus drive enable; top level forms bus = bus_oe ? bus_out : 1'bz.
- rx_data  out  64  payload of the last accepted packet.
- rx_src  out  4  source address of the last accepted packet.
- rx_valid  out  1  one-cycle pulse when a packet is accepted.
- rx_crc_err  out  1  one-cycle pulse: addressed packet, CRC mismatch.
- rx_frame_err  out  1  one-cycle pulse: end bit or datasize field invalid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Frame, LSB first, one bit per clock:
  - bit0 start = 0
  - [4:1] src
  - [8:5] dst
  - [10:9] datasize = 2'b11
  - [74:11] data
  - [78:75] crc
  - [79] end = 1
- Reset (async): state = WAIT_IDLE, bit counter = 0, shift register cleared.
  - bus_oe = 0, bus_out = 1, all pulses = 0, rx_data = 0, rx_src = 0, busy = 1.
  - Reset mid-packet or mid-ack releases the bus immediately and drops the partial packet.
- WAIT_IDLE: stay until bus_in == 1 is sampled, then go to IDLE. Prevents a trailing low from being taken as a start bit.
- IDLE: bus_in == 0 sampled means a start bit. Store bit0, set count = 1, go to RECV.
- RECV: store bus_in at bit[count] and increment count. After bit 79 is stored, go to CHECK.
- CHECK (exactly 1 cycle; the sender holds the bus low this cycle, and that level is ignored). Evaluate in priority order:
  1. end bit != 1 or datasize != 2'b11: pulse rx_frame_err, go to WAIT_IDLE.
  2. dst != NODE_ADDR: no pulse, go to WAIT_IDLE (silent drop).
  3. CRC check fails: pulse rx_crc_err, no ack, go to WAIT_IDLE.
  4. Otherwise: latch rx_data and rx_src, pulse rx_valid, go to ACK.
- All outputs are registered.
  - The rx_valid, rx_crc_err and rx_frame_err pulses are high in the cycle after CHECK.
  - rx_data and rx_src update in that same cycle and hold until the next accept.
- ACK: bus_oe = 1, bus_out = 1 for exactly ACK_LEN cycles, starting the cycle after CHECK. Timing relative to start bit at cycle 0:
  - Ack occupies cycles 81 .. 80+ACK_LEN.
  - Then bus_oe = 0 and the block goes to WAIT_IDLE.
- bus_in is ignored in ACK and CHECK. A low seen in WAIT_IDLE never starts a packet.
- bus_oe is never asserted outside ACK.
- Back-to-back packets: a start bit is accepted in the first IDLE cycle, which is earliest 1 cycle after the bus is seen high.

Optional Feature:
- Macro: RX_CRC_CALC_EN.
- Defined: the CRC is computed, not compared literally.
  - Generator = {1, crc[3:0]}.
  - 4-bit remainder r is cleared at the start bit.
  - For each data bit b (bit 11 first through bit 74, serially as received): fb = r[3]^b; r = {r[2:0],1'b0} ^ (fb ? crc : 4'b0).
  - The check passes when r == packet[78:75].
- Undefined: the check passes when packet[78:75] == crc; no remainder logic is synthesised.

Test Plan:
- Accept: NODE_ADDR=2, crc=4'hA. Drive frame src=1, dst=2, data=64'h0123_4567_89AB_CDEF, crc field A, end=1. Required:
  - rx_valid pulses at cycle 81.
  - rx_data = 64'h0123456789ABCDEF, rx_src = 1.
  - bus_oe = 1 and bus_out = 1 in cycles 81-82, then bus_oe = 0.
- Address miss: same frame with dst=3. Required: no pulses, bus_oe stays 0, block returns to IDLE after the bus reads 1.
- CRC mismatch: dst=2, crc field 4'h5, crc=4'hA. Required: rx_crc_err pulses at cycle 81, no ack, rx_data unchanged.
- Frame error: end bit 0. Required: rx_frame_err pulses at cycle 81, no ack. Repeat with datasize 2'b01: same response.
- Reset mid-ack: assert reset in cycle 81. Required: bus_oe = 0 the same cycle (async); after release the block waits for bus = 1, and a subsequent valid packet is accepted.
- RX_CRC_CALC_EN: crc=4'h3, data=64'h1, crc field set to the computed remainder. Required: rx_valid. Same packet with the crc field XOR 1: rx_crc_err.
